game_timer_ctrl: RTL and testbench
==================================

Name: game_timer_ctrl

Overview:
- Game-round timebase controller for the rhythm game.
- Replaces free-running derived-clock dividers with single-clock enable pulses: a beat tick (note-spawn / scroll rate) and a second tick.
- Sequences a round countdown with a start/pause/abort FSM.
- Sits between the button front-end and the note scheduler/score/display logic.

Parameters:
- CLK_HZ, 50_000_000, system clock frequency in Hz; must be divisible by TICKS_PER_SEC.
- TICKS_PER_SEC, 4, beat ticks per second.
- GAME_SEC, 60, round length in seconds; range 1..99.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle pulse; begins a round
- pause_req  in  1  single-cycle pulse; toggles RUN/PAUSE
- abort  in  1  single-cycle pulse; returns to IDLE
- beat_tick  out  1  one-cycle enable at beat rate, RUN only
- sec_tick  out  1  one-cycle enable each elapsed second, RUN only
- sec_left  out  7  remaining seconds, binary
- state  out  2  00 IDLE, 01 RUN, 10 PAUSE, 11 DONE
- done  out  1  one-cycle pulse when the round expires
- bcd_tens  out  4  tens digit of sec_left (see Optional Feature)
- bcd_ones  out  4  ones digit of sec_left (see Optional Feature)

Behaviour:
- Reset / one clock:
  - One clock, clk. Reset is asynchronous and active-low on rst_n.
  - Reset values: state=IDLE, sec_left=GAME_SEC, beat_tick=0, sec_tick=0, done=0, bcd outputs = digits of GAME_SEC (0 when feature off), internal counters=0.
  - Reset asserted mid-round aborts immediately. No tick or done pulse is emitted after reset deasserts until a new start.
- Internal counters:
  - DIV = CLK_HZ/TICKS_PER_SEC.
  - div_cnt: $clog2(DIV) bits, wraps at DIV-1.
  - beat_cnt: $clog2(TICKS_PER_SEC) bits, minimum width 1, wraps at TICKS_PER_SEC-1.
- Priority: abort > start > pause_req.
- IDLE:
  - start → RUN.
  - On the same edge: sec_left=GAME_SEC, div_cnt=0, beat_cnt=0.
  - pause_req is ignored.
- RUN:
  - div_cnt increments every cycle.
  - On the edge where div_cnt==DIV-1: div_cnt→0 and beat_tick registers high for one cycle.
  - First beat_tick is visible in the DIV-th cycle after RUN entry.
  - On that same edge, beat_cnt increments. If beat_cnt==TICKS_PER_SEC-1, it wraps to 0, sec_tick registers high (coincident with beat_tick), and sec_left decrements.
  - If the decrement takes sec_left to 0: state→DONE and done registers high on that same edge, coincident with the final sec_tick.
  - pause_req → PAUSE.
  - start is ignored.
- PAUSE:
  - All counters frozen; no ticks.
  - pause_req → RUN; counters resume from their frozen values, so a partial beat is preserved.
  - start is ignored.
- DONE:
  - sec_left holds 0.
  - start → RUN with a fresh load.
  - pause_req is ignored.
- abort from any state: → IDLE, sec_left=GAME_SEC, counters=0, no tick or done pulse that cycle.
- Simultaneous events:
  - pause_req on the same edge as a wrap in RUN: the wrap completes (ticks asserted), then PAUSE.
  - pause_req on the same edge as expiry: DONE wins; pause_req is dropped.
- All outputs are registered.
- Elaboration-time check: CLK_HZ % TICKS_PER_SEC == 0 and GAME_SEC in 1..99; otherwise $error.

Optional Feature:
- Macro: GAME_TIMER_BCD_EN.
- Defined:
  - bcd_tens/bcd_ones carry the registered BCD of sec_left for the seven-segment driver.
  - Updated on the same edge as sec_left, so zero extra latency.
  - Implemented as a divide-by-10 lookup on the next value of sec_left.
- Undefined:
  - bcd_tens and bcd_ones are tied to 0.
  - No BCD logic is synthesized.

Decomposition:
- Package game_pkg holds:
  - state typedef game_state_t (IDLE/RUN/PAUSE/DONE encodings).
  - Default constants CLK_HZ_DEF and GAME_SEC_DEF, shared with the note scheduler and display.
- One sub-module, tick_prescaler:
  - Contains div_cnt and beat_cnt with enable/clear inputs.
  - Outputs beat_tick and sec_wrap.
- FSM and sec_left stay in the top module.

Test Plan (CLK_HZ=20, TICKS_PER_SEC=4, GAME_SEC=3, DIV=5):
1. Reset then start pulse → state=01 next edge. beat_tick in cycles 5, 10, 15, 20 after entry. sec_tick only in cycle 20. sec_left 3→2.
2. Run uninterrupted → sec_left reaches 0 at cycle 60 with done=1, sec_tick=1, state=11. No further ticks for ≥50 cycles.
3. pause_req at cycle 7, resume after 30 idle cycles → no ticks during PAUSE. Next beat_tick 3 cycles after resume.
4. abort in PAUSE with sec_left=1 → state=00, sec_left=3. Subsequent pause_req is ignored.
5. start and pause_req on the same cycle in IDLE → RUN, not PAUSE. start during RUN → no reload.
6. rst_n low mid-RUN for a fraction of a cycle → outputs immediately at reset values. With GAME_TIMER_BCD_EN and GAME_SEC=12: bcd_tens=1, bcd_ones=2, then 1/1 after the first sec_tick.

Source files
------------

// File: rtl/game_pkg.sv
// Shared types and defaults for the rhythm-game timebase, note scheduler and display.
package game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_DONE  = 2'b11
  } game_state_t;

  localparam int unsigned CLK_HZ_DEF        = 50_000_000;
  localparam int unsigned TICKS_PER_SEC_DEF = 4;
  localparam int unsigned GAME_SEC_DEF      = 60;

  // Divide-by-10 lookup: {tens, ones} for a value in 0..99.
  function automatic logic [7:0] bin2bcd(input logic [6:0] v);
    logic [3:0] tens;
    logic [6:0] ones;
    tens = 4'd0;
    for (int i = 9; i >= 1; i--) begin
      if ((tens == 4'd0) && (v >= 7'(i * 10))) begin
        tens = 4'(i);
      end else begin
        tens = tens;
      end
    end
    ones = v - 7'(int'(tens) * 10);
    return {tens, ones[3:0]};
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Beat prescaler: div_cnt divides the clock down to beats, beat_cnt groups beats into seconds.
module tick_prescaler #(
  parameter int DIV   = 5,
  parameter int TICKS = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic clr_i,
  output logic beat_tick_o,
  output logic sec_wrap_o
);

  localparam int DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BEAT_W = (TICKS > 1) ? $clog2(TICKS) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV - 1);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(TICKS - 1);

  logic [DIV_W-1:0]  div_cnt_q,  div_cnt_d;
  logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;

  // Next-state of both counters; strobes are combinational and registered by the parent.
  always_comb begin
    div_cnt_d   = div_cnt_q;
    beat_cnt_d  = beat_cnt_q;
    beat_tick_o = 1'b0;
    sec_wrap_o  = 1'b0;
    if (clr_i) begin
      div_cnt_d  = '0;
      beat_cnt_d = '0;
    end else if (en_i) begin
      if (div_cnt_q == DIV_LAST) begin
        div_cnt_d   = '0;
        beat_tick_o = 1'b1;
        if (beat_cnt_q == BEAT_LAST) begin
          beat_cnt_d = '0;
          sec_wrap_o = 1'b1;
        end else begin
          beat_cnt_d = beat_cnt_q + BEAT_W'(1);
        end
      end else begin
        div_cnt_d = div_cnt_q + DIV_W'(1);
      end
    end else begin
      div_cnt_d  = div_cnt_q;
      beat_cnt_d = beat_cnt_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q  <= '0;
      beat_cnt_q <= '0;
    end else begin
      div_cnt_q  <= div_cnt_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

endmodule

// File: rtl/game_timer_ctrl.sv
// Round timebase: beat/second enable pulses and a start/pause/abort countdown FSM.
// Optional BCD outputs of sec_left are enabled by defining GAME_TIMER_BCD_EN.
module game_timer_ctrl
  import game_pkg::*;
#(
  parameter int CLK_HZ        = int'(CLK_HZ_DEF),
  parameter int TICKS_PER_SEC = int'(TICKS_PER_SEC_DEF),
  parameter int GAME_SEC      = int'(GAME_SEC_DEF)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       pause_req,
  input  logic       abort,
  output logic       beat_tick,
  output logic       sec_tick,
  output logic [6:0] sec_left,
  output logic [1:0] state,
  output logic       done,
  output logic [3:0] bcd_tens,
  output logic [3:0] bcd_ones
);

  localparam int         DIV      = CLK_HZ / TICKS_PER_SEC;
  localparam logic [6:0] SEC_LOAD = 7'(GAME_SEC);

  if (((CLK_HZ % TICKS_PER_SEC) != 0) || (GAME_SEC < 1) || (GAME_SEC > 99)) begin : g_param_check
    $error("game_timer_ctrl: CLK_HZ must be divisible by TICKS_PER_SEC and GAME_SEC must be 1..99");
  end

  game_state_t state_q, state_d;
  logic [6:0]  sec_left_q, sec_left_d;
  logic        beat_q, beat_d, sec_tick_q, sec_tick_d, done_q, done_d;
  logic        pre_en_s, pre_clr_s, beat_wrap_s, sec_wrap_s;

  tick_prescaler #(
    .DIV   (DIV),
    .TICKS (TICKS_PER_SEC)
  ) u_prescaler (
    .clk         (clk),
    .rst_n       (rst_n),
    .en_i        (pre_en_s),
    .clr_i       (pre_clr_s),
    .beat_tick_o (beat_wrap_s),
    .sec_wrap_o  (sec_wrap_s)
  );

  // FSM next-state, countdown and tick strobes; abort beats start beats pause_req.
  always_comb begin
    state_d    = state_q;
    sec_left_d = sec_left_q;
    beat_d     = 1'b0;
    sec_tick_d = 1'b0;
    done_d     = 1'b0;
    pre_en_s   = 1'b0;
    pre_clr_s  = 1'b0;
    if (abort) begin
      state_d    = ST_IDLE;
      sec_left_d = SEC_LOAD;
      pre_clr_s  = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_d    = ST_RUN;
            sec_left_d = SEC_LOAD;
            pre_clr_s  = 1'b1;
          end else begin
            state_d = state_q;
          end
        end
        ST_RUN: begin
          pre_en_s   = 1'b1;
          beat_d     = beat_wrap_s;
          sec_tick_d = sec_wrap_s;
          // Expiry outranks a coincident pause request.
          if (sec_wrap_s && (sec_left_q == 7'd1)) begin
            sec_left_d = 7'd0;
            state_d    = ST_DONE;
            done_d     = 1'b1;
          end else begin
            if (sec_wrap_s) begin
              sec_left_d = sec_left_q - 7'd1;
            end else begin
              sec_left_d = sec_left_q;
            end
            if (pause_req) begin
              state_d = ST_PAUSE;
            end else begin
              state_d = ST_RUN;
            end
          end
        end
        ST_PAUSE: begin
          if (pause_req) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_PAUSE;
          end
        end
        default: begin
          state_d    = ST_IDLE;
          sec_left_d = SEC_LOAD;
          pre_clr_s  = 1'b1;
        end
      endcase
    end
  end

  // State, countdown and output pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      sec_left_q <= SEC_LOAD;
      beat_q     <= 1'b0;
      sec_tick_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sec_left_q <= sec_left_d;
      beat_q     <= beat_d;
      sec_tick_q <= sec_tick_d;
      done_q     <= done_d;
    end
  end

`ifdef GAME_TIMER_BCD_EN
  localparam logic [7:0] BCD_LOAD = bin2bcd(SEC_LOAD);
  logic [3:0] bcd_tens_q, bcd_ones_q;
  logic [7:0] bcd_next_s;

  assign bcd_next_s = bin2bcd(sec_left_d);

  // BCD digits track the next sec_left so they change on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd_tens_q <= BCD_LOAD[7:4];
      bcd_ones_q <= BCD_LOAD[3:0];
    end else begin
      bcd_tens_q <= bcd_next_s[7:4];
      bcd_ones_q <= bcd_next_s[3:0];
    end
  end

  assign bcd_tens = bcd_tens_q;
  assign bcd_ones = bcd_ones_q;
`else
  assign bcd_tens = 4'd0;
  assign bcd_ones = 4'd0;
`endif

  assign state     = state_q;
  assign sec_left  = sec_left_q;
  assign beat_tick = beat_q;
  assign sec_tick  = sec_tick_q;
  assign done      = done_q;

endmodule

// File: tb/tb_game_timer_ctrl.sv
// Directed bench for game_timer_ctrl with CLK_HZ=20, TICKS_PER_SEC=4 (DIV=5).
module tb_game_timer_ctrl;

`ifdef GAME_TIMER_BCD_EN
  localparam int GS = 12;
  localparam logic [3:0] T_RST = 4'd1, O_RST = 4'd2, T_SEC1 = 4'd1, O_SEC1 = 4'd1;
`else
  localparam int GS = 3;
  localparam logic [3:0] T_RST = 4'd0, O_RST = 4'd0, T_SEC1 = 4'd0, O_SEC1 = 4'd0;
`endif

  logic       clk = 1'b0;
  logic       rst_n, start, pause_req, abort;
  logic       beat_tick, sec_tick, done;
  logic [6:0] sec_left;
  logic [1:0] state;
  logic [3:0] bcd_tens, bcd_ones;

  int checks = 0;
  int failures = 0;
  int extra;

  game_timer_ctrl #(.CLK_HZ(20), .TICKS_PER_SEC(4), .GAME_SEC(GS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .pause_req (pause_req),
    .abort     (abort),
    .beat_tick (beat_tick),
    .sec_tick  (sec_tick),
    .sec_left  (sec_left),
    .state     (state),
    .done      (done),
    .bcd_tens  (bcd_tens),
    .bcd_ones  (bcd_ones)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic count_ticks(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      step(1);
      cnt += int'(beat_tick) + int'(sec_tick) + int'(done);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; pause_req = 1'b0; abort = 1'b0;
    #12;
    check("rst_state", state, 2'b00);
    check("rst_sec", sec_left, GS);
    check("rst_beat", beat_tick, 1'b0);
    check("rst_sectick", sec_tick, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_bcd_t", bcd_tens, T_RST);
    check("rst_bcd_o", bcd_ones, O_RST);
    rst_n = 1'b1;
    step(2);

    // 1: first second of a round
    start = 1'b1; step(1); start = 1'b0;
    check("t1_state", state, 2'b01);
    check("t1_load", sec_left, GS);
    for (int k = 1; k <= 20; k++) begin
      step(1);
      check("t1_beat", beat_tick, (k % 5) == 0);
      check("t1_sectick", sec_tick, k == 20);
    end
    check("t1_sec", sec_left, GS - 1);
    check("t1_bcd_t", bcd_tens, T_SEC1);
    check("t1_bcd_o", bcd_ones, O_SEC1);

    // 2: run to expiry, then silence
    for (int k = 21; k <= GS * 20; k++) begin
      step(1);
      check("t2_done", done, k == GS * 20);
    end
    check("t2_state", state, 2'b11);
    check("t2_sec", sec_left, 7'd0);
    check("t2_sectick", sec_tick, 1'b1);
    count_ticks(50, extra);
    check("t2_quiet", extra, 0);
    check("t2_hold", state, 2'b11);

    // 3: pause mid-beat, resume keeps the partial beat
    start = 1'b1; step(1); start = 1'b0;
    check("t3_restart", state, 2'b01);
    check("t3_reload", sec_left, GS);
    step(5);
    check("t3_beat5", beat_tick, 1'b1);
    step(1);
    pause_req = 1'b1; step(1); pause_req = 1'b0;
    check("t3_paused", state, 2'b10);
    count_ticks(30, extra);
    check("t3_quiet", extra, 0);
    check("t3_still_paused", state, 2'b10);
    pause_req = 1'b1; step(1); pause_req = 1'b0;
    check("t3_resume", state, 2'b01);
    check("t3_r0", beat_tick, 1'b0);
    step(1); check("t3_r1", beat_tick, 1'b0);
    step(1); check("t3_r2", beat_tick, 1'b0);
    step(1); check("t3_r3", beat_tick, 1'b1);

    // 4: abort from PAUSE with one second left
    step(5 * (4 * (GS - 1) - 2));
    check("t4_sec1", sec_left, 7'd1);
    check("t4_sectick", sec_tick, 1'b1);
    pause_req = 1'b1; step(1); pause_req = 1'b0;
    check("t4_paused", state, 2'b10);
    abort = 1'b1; step(1); abort = 1'b0;
    check("t4_idle", state, 2'b00);
    check("t4_sec", sec_left, GS);
    check("t4_nobeat", beat_tick, 1'b0);
    pause_req = 1'b1; step(1); pause_req = 1'b0;
    check("t4_pause_ign", state, 2'b00);

    // 5: start beats pause in IDLE; start in RUN does not reload; pause on a wrap
    start = 1'b1; pause_req = 1'b1; step(1); start = 1'b0; pause_req = 1'b0;
    check("t5_run", state, 2'b01);
    step(4); check("t5_e4", beat_tick, 1'b0);
    step(1); check("t5_e5", beat_tick, 1'b1);
    step(3);
    start = 1'b1; step(1); start = 1'b0;
    check("t5_start_ign", state, 2'b01);
    step(1); check("t5_e10", beat_tick, 1'b1);
    step(4);
    pause_req = 1'b1; step(1); pause_req = 1'b0;
    check("t5_wrap_beat", beat_tick, 1'b1);
    check("t5_wrap_pause", state, 2'b10);
    abort = 1'b1; step(1); abort = 1'b0;
    check("t5_abort", state, 2'b00);

    // 5b: pause on the expiry edge is dropped
    start = 1'b1; step(1); start = 1'b0;
    step(GS * 20 - 1);
    pause_req = 1'b1; step(1); pause_req = 1'b0;
    check("t5_exp_done", done, 1'b1);
    check("t5_exp_state", state, 2'b11);
    check("t5_exp_sec", sec_left, 7'd0);
    step(1);
    check("t5_exp_hold", state, 2'b11);
    check("t5_exp_pulse", done, 1'b0);

    // 6: asynchronous reset mid-run
    start = 1'b1; step(1); start = 1'b0;
    step(20);
    check("t6_pre_sec", sec_left, GS - 1);
    #1 rst_n = 1'b0;
    #1;
    check("t6_state", state, 2'b00);
    check("t6_sec", sec_left, GS);
    check("t6_bcd_t", bcd_tens, T_RST);
    check("t6_bcd_o", bcd_ones, O_RST);
    #2 rst_n = 1'b1;
    count_ticks(30, extra);
    check("t6_quiet", extra, 0);
    check("t6_idle", state, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
